// File: rtl/bf16_to_int20.sv
// bfloat16 to signed fixed-point accumulator converter (acc = value * 2^INT_ACC_OFFSET).
// Two-stage valid/ready pipeline with saturation/NaN flags, sticky status and a saturation counter.
module bf16_to_int20 #(
    parameter int OUT_W          = 20,
    parameter int BF16_BIAS      = 127,
    parameter int INT_ACC_OFFSET = 24,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_bf16,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_int,
    output logic             out_sat,
    output logic             out_nan,
    input  logic             sticky_clr,
    output logic             sticky_sat,
    output logic             sticky_nan,
    output logic [CNT_W-1:0] sat_count
);

    localparam int SHIFT_OFF = BF16_BIAS - INT_ACC_OFFSET + 7;
    // Any left shift beyond SH_CAP already exceeds the output range for an 8-bit significand.
    localparam int SH_CAP    = OUT_W - 7;
    localparam int MAG_W     = OUT_W + 1;
    localparam logic [MAG_W-1:0] POS_MAX = MAG_W'((1 << (OUT_W - 1)) - 1);
    localparam logic [MAG_W-1:0] NEG_MAG = MAG_W'(1 << (OUT_W - 1));

    typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_t;

    logic               vld_p1;
    logic               sign_p1;
    logic [7:0]         sig_p1;
    logic signed [9:0]  shift_p1;
    cls_t               cls_p1;

    logic               ld_p2;
    logic [MAG_W-1:0]   mag_p1;
    logic [OUT_W-1:0]   nxt_int;
    logic               nxt_sat;
    logic               nxt_nan;
    logic [OUT_W:0]     sat_res;

    function automatic logic [MAG_W-1:0] shift_mag(input logic [7:0] sig, input logic signed [9:0] sh);
        int s;
        logic [4:0] lsh;
        s = int'(sh);
        if (s >= 0) begin
            lsh = (s > SH_CAP) ? 5'(SH_CAP) : 5'(s);
            return MAG_W'(sig) << lsh;
        end else if (s >= -7) begin
            return MAG_W'(sig >> 3'(-s));
        end
        return '0;
    endfunction

    // Returns {sat, value}; the negative side can reach one step further than the positive side.
    function automatic logic [OUT_W:0] saturate(input logic sign, input logic [MAG_W-1:0] mag);
        logic [MAG_W-1:0] neg;
        neg = ~mag + MAG_W'(1);
        if (!sign) begin
            if (mag > POS_MAX) return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
            return {1'b0, mag[OUT_W-1:0]};
        end
        if (mag > NEG_MAG) return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        return {1'b0, neg[OUT_W-1:0]};
    endfunction

    assign ld_p2    = !out_valid || out_ready;
    assign in_ready = !vld_p1 || ld_p2;

    // Stage 1: decode fields and classify
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            sign_p1  <= in_bf16[15];
            sig_p1   <= {1'b1, in_bf16[6:0]};
            shift_p1 <= $signed({2'b00, in_bf16[14:7]}) - 10'(SHIFT_OFF);
            if (in_bf16[14:7] == 8'd0)
                cls_p1 <= CLS_ZERO;
            else if (in_bf16[14:7] == 8'hFF)
                cls_p1 <= (in_bf16[6:0] != 7'd0) ? CLS_NAN : CLS_INF;
            else
                cls_p1 <= CLS_NORM;
        end
    end

    always_comb begin
        mag_p1  = shift_mag(sig_p1, shift_p1);
        sat_res = saturate(sign_p1, mag_p1);
        nxt_int = '0;
        nxt_sat = 1'b0;
        nxt_nan = 1'b0;
        case (cls_p1)
            CLS_NORM: begin
                nxt_int = sat_res[OUT_W-1:0];
                nxt_sat = sat_res[OUT_W];
            end
            CLS_INF: begin
                nxt_int = sign_p1 ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
                nxt_sat = 1'b1;
            end
            CLS_NAN:  nxt_nan = 1'b1;
            default:  nxt_int = '0;
        endcase
    end

    // Stage 2: shift, saturate and hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_int   <= '0;
            out_sat   <= 1'b0;
            out_nan   <= 1'b0;
        end else if (ld_p2) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_int <= nxt_int;
                out_sat <= nxt_sat;
                out_nan <= nxt_nan;
            end
        end
    end

    // Status follows emitted items only; a clear wins over a same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_sat <= 1'b0;
            sticky_nan <= 1'b0;
            sat_count  <= '0;
        end else if (sticky_clr) begin
            sticky_sat <= 1'b0;
            sticky_nan <= 1'b0;
            sat_count  <= '0;
        end else if (out_valid && out_ready) begin
            if (out_sat) begin
                sticky_sat <= 1'b1;
                if (sat_count != {CNT_W{1'b1}}) sat_count <= sat_count + CNT_W'(1);
            end
            if (out_nan) sticky_nan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bf16_to_int20.sv
// Randomized and directed bench for bf16_to_int20 against an arithmetic reference model.
module tb_bf16_to_int20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_bf16 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] out_int;
    logic        out_sat;
    logic        out_nan;
    logic        sticky_clr = 1'b0;
    logic        sticky_sat;
    logic        sticky_nan;
    logic [15:0] sat_count;

    int n_vec = 0;
    int n_err = 0;

    logic [21:0] exp_q[$];
    logic        m_ssat = 1'b0;
    logic        m_snan = 1'b0;
    int          m_cnt  = 0;

    logic [15:0] bp_vec [4] = '{16'h3700, 16'h3AC0, 16'hBAC0, 16'h34FF};

    bf16_to_int20 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bf16    (in_bf16),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_int    (out_int),
        .out_sat    (out_sat),
        .out_nan    (out_nan),
        .sticky_clr (sticky_clr),
        .sticky_sat (sticky_sat),
        .sticky_nan (sticky_nan),
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Value * 2^24 truncated toward zero, then clamped to the signed 20-bit range. Returns {nan, sat, int}.
    function automatic logic [21:0] ref_conv(input logic [15:0] b);
        int     e;
        int     p;
        longint v;
        longint sig;
        e = int'(b[14:7]);
        if (e == 0) return '0;
        if (e == 255) begin
            if (b[6:0] != 7'd0) return {1'b1, 1'b0, 20'h0};
            return {1'b0, 1'b1, b[15] ? 20'h80000 : 20'h7FFFF};
        end
        sig = 128 + longint'(b[6:0]);
        p = e - 127 + 24 - 7;
        if (p > 30)       v = longint'(1) << 40;
        else if (p >= 0)  v = sig * (longint'(1) << p);
        else if (p < -20) v = 0;
        else              v = sig / (longint'(1) << (-p));
        if (b[15]) v = -v;
        if (v > 524287)   return {1'b0, 1'b1, 20'h7FFFF};
        if (v < -524288)  return {1'b0, 1'b1, 20'h80000};
        return {2'b00, v[19:0]};
    endfunction

    function automatic logic [15:0] rand_bf16();
        int   r;
        logic [7:0] e;
        r = $urandom_range(0, 9);
        if (r < 7)       e = 8'($urandom_range(98, 126));
        else if (r == 7) e = 8'hFF;
        else if (r == 8) e = 8'h00;
        else             e = 8'($urandom_range(0, 255));
        return {1'($urandom), e, 7'($urandom)};
    endfunction

    // Scoreboard and status model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("sticky", 32'({sticky_sat, sticky_nan, sat_count}), 32'({m_ssat, m_snan, 16'(m_cnt)}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'({out_nan, out_sat, out_int}), 32'hFFFF_FFFF);
                end else begin
                    logic [21:0] e;
                    e = exp_q.pop_front();
                    chk("out", 32'({out_nan, out_sat, out_int}), 32'(e));
                    if (e[20]) begin
                        m_ssat = 1'b1;
                        if (m_cnt < 65535) m_cnt++;
                    end
                    if (e[21]) m_snan = 1'b1;
                end
            end
            if (sticky_clr) begin
                m_ssat = 1'b0;
                m_snan = 1'b0;
                m_cnt  = 0;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_conv(in_bf16));
        end
    end

    // Single item through an idle pipeline with out_ready high; checks latency and value.
    task automatic xfer(input string tag, input logic [15:0] v, input logic [21:0] exp);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_bf16  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
        chk(tag, 32'({out_nan, out_sat, out_int}), 32'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        int          idx;
        int          nv;
        logic        take;
        logic [21:0] r;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", 32'({out_valid, out_sat, out_nan, sticky_sat, sticky_nan, out_int}), 32'd0);
        chk("rst_cnt", 32'(sat_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        xfer("nom_128",   16'h3700, {2'b00, 20'd128});
        xfer("nom_24576", 16'h3AC0, {2'b00, 20'd24576});
        xfer("nom_neg",   16'hBAC0, {2'b00, 20'hFA000});
        xfer("trunc_p7",  16'h34FF, {2'b00, 20'd7});
        xfer("trunc_n7",  16'hB4FF, {2'b00, 20'hFFFF9});
        xfer("shift_m7",  16'h3380, {2'b00, 20'd1});
        xfer("underflow", 16'h3300, {2'b00, 20'd0});
        xfer("sat_pos",   16'h3D00, {2'b01, 20'h7FFFF});
        xfer("neg_edge",  16'hBD00, {2'b00, 20'h80000});
        xfer("ninf",      16'hFF80, {2'b01, 20'h80000});
        xfer("pinf",      16'h7F80, {2'b01, 20'h7FFFF});
        chk("sat_count3", 32'(sat_count), 32'd3);
        chk("sticky_sat1", 32'(sticky_sat), 32'd1);

        xfer("nan",       16'h7FC0, {2'b10, 20'd0});
        chk("sticky_nan1", 32'(sticky_nan), 32'd1);
        xfer("denorm",    16'h8001, {2'b00, 20'd0});
        xfer("zero",      16'h0000, {2'b00, 20'd0});

        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        chk("clr", 32'({sticky_sat, sticky_nan, sat_count}), 32'd0);

        // Backpressure: four back-to-back inputs with the consumer stalled
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        in_bf16 = bp_vec[0];
        repeat (6) begin
            @(negedge clk);
            take = in_ready;
            @(posedge clk); #1;
            if (take) begin
                idx++;
                if (idx < 4) in_bf16 = bp_vec[idx];
                else in_valid = 1'b0;
            end
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        r = ref_conv(bp_vec[0]);
        chk("bp_hold", 32'({out_valid, out_int}), 32'({1'b1, r[19:0]}));
        out_ready = 1'b1;
        nv = 0;
        repeat (4) begin
            @(negedge clk);
            take = in_ready && in_valid;
            if (out_valid) nv++;
            @(posedge clk); #1;
            if (take) begin
                idx++;
                if (idx < 4) in_bf16 = bp_vec[idx];
                else in_valid = 1'b0;
            end
        end
        chk("bp_no_gap", 32'(nv), 32'd4);
        chk("bp_all_in", 32'(idx), 32'd4);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_bf16 = 16'h3AC0;
        @(posedge clk); #1;
        in_bf16 = 16'h3700;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("full_before_rst", 32'({out_valid, in_ready}), 32'b10);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'({out_valid, out_sat, out_nan, out_int}), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        m_ssat = 1'b0;
        m_snan = 1'b0;
        m_cnt  = 0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        nv = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("no_stale", 32'(nv), 32'd0);

        // Random traffic with random backpressure and occasional clears
        repeat (600) begin
            @(posedge clk); #1;
            in_valid   = ($urandom_range(0, 3) != 0);
            in_bf16    = rand_bf16();
            out_ready  = ($urandom_range(0, 3) != 0);
            sticky_clr = ($urandom_range(0, 24) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        sticky_clr = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
